// File: rtl/shift_sequencer_pkg.sv
// Shared types and defaults for the shift_sequencer block.
package shift_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        DONE
    } state_e;

endpackage

// File: rtl/shift_bit_counter.sv
// Loadable down-counter that indexes the bit currently being shifted out.
module shift_bit_counter #(
    parameter int CW = 3
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    logic [CW-1:0] count_d;
    logic [CW-1:0] count_q;

    assign zero  = (count_q == '0);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && !zero) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Serializes a parallel word MSB-first into an external SIPO register, then returns its parallel output.
// Optional build macro SHIFT_SEQUENCER_LOOPBACK_CHECK_EN adds a loopback mismatch flag.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             sr_en,
    output logic             sr_d,
    input  logic [WIDTH-1:0] sr_q,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SHIFT_SEQUENCER_LOOPBACK_CHECK_EN
    output logic             mismatch,
`endif
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_d, state_q;
    logic [WIDTH-1:0] hold_d, hold_q;
    logic [WIDTH-1:0] out_data_d, out_data_q;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0]    cnt;

    shift_bit_counter #(.CW(CW)) u_bit_counter (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (cnt_load),
        .load_val (LAST_BIT),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d    = state_q;
        hold_d     = hold_q;
        out_data_d = out_data_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        in_ready   = 1'b0;
        sr_en      = 1'b0;
        sr_d       = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    hold_d   = in_data;
                    cnt_load = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                sr_en   = 1'b1;
                sr_d    = hold_q[cnt];
                cnt_dec = 1'b1;
                if (cnt_zero) state_d = CAPTURE;
            end
            CAPTURE: begin
                // The register has taken its last shift edge, so sr_q is final here.
                out_data_d = sr_q;
                state_d    = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_data = out_data_q;

`ifdef SHIFT_SEQUENCER_LOOPBACK_CHECK_EN
    logic mismatch_d, mismatch_q;

    always_comb begin
        mismatch_d = mismatch_q;
        if (state_q == CAPTURE) begin
            mismatch_d = (sr_q != hold_q);
        end else if (state_q == DONE && out_ready) begin
            mismatch_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule
